// File: rtl/iirbandpass_mc.sv
// Multi-channel second-order IIR bandpass filter. One shared shift-and-add datapath
// processes one channel per clock after each sample strobe.
module iirbandpass_mc #(
    parameter int inputwidth  = 16,
    parameter int outputwidth = 16,
    parameter int channels    = 4,
    parameter int fracbits    = 10
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              ena,
    input  logic [channels*inputwidth-1:0]    d,
    input  logic                              cfg_wr,
    input  logic [3:0]                        cfg_ch,
    input  logic [3:0]                        cfg_a1,
    input  logic [3:0]                        cfg_a2,
    input  logic [3:0]                        cfg_b,
    output logic [channels*outputwidth-1:0]   q,
    output logic                              q_valid,
    output logic                              busy,
    output logic                              overrun
);

    localparam int AW = outputwidth + fracbits + 3;
    localparam int CW = (channels > 1) ? $clog2(channels) : 1;
    localparam logic [CW-1:0] LAST_CH = CW'(channels - 1);
    localparam logic [3:0] B_MAX = (fracbits > 15) ? 4'd15 : 4'(fracbits);
    localparam logic [3:0] B_RST = (fracbits < 10) ? B_MAX : 4'd10;
    localparam logic signed [AW-1:0] Q_MAX = AW'((64'sd1 <<< (outputwidth - 1)) - 64'sd1);
    localparam logic signed [AW-1:0] Q_MIN = AW'(-(64'sd1 <<< (outputwidth - 1)));

    typedef enum logic {IDLE, RUN} state_t;

    state_t state, state_nx;
    logic [CW-1:0] ch;
    logic start, step;

    logic [3:0] a1_live [channels];
    logic [3:0] a2_live [channels];
    logic [3:0] b_live  [channels];
    logic [3:0] a1_snap [channels];
    logic [3:0] a2_snap [channels];
    logic [3:0] b_snap  [channels];
    logic signed [inputwidth-1:0]  d_cap [channels];
    logic signed [outputwidth-1:0] x1 [channels];
    logic signed [outputwidth-1:0] x2 [channels];
    logic signed [AW-1:0]          y1 [channels];
    logic signed [AW-1:0]          y2 [channels];
    logic [outputwidth-1:0]        q_reg [channels];

    logic signed [outputwidth-1:0] x0;
    logic signed [AW-1:0] diff, xt, y0, yq;
    logic [outputwidth-1:0] q_sat;

    function automatic logic [3:0] clamp_a(input logic [3:0] v);
        return (v == 4'd0) ? 4'd1 : v;
    endfunction

    function automatic logic [3:0] clamp_b(input logic [3:0] v);
        return (v > B_MAX) ? B_MAX : v;
    endfunction

    always_comb begin
        state_nx = state;
        start    = 1'b0;
        step     = 1'b0;
        case (state)
            IDLE: begin
                if (ena) begin
                    start    = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (ch == LAST_CH) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            ch      <= '0;
            q_valid <= 1'b0;
            overrun <= 1'b0;
        end else begin
            state   <= state_nx;
            q_valid <= step && (ch == LAST_CH);
            if (start)
                ch <= '0;
            else if (step)
                ch <= ch + 1'b1;
            if (ena && state == RUN)
                overrun <= 1'b1;
        end
    end

    // Live coefficients accept writes at any time; the running frame reads only the snapshot.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < channels; i++) begin
                a1_live[i] <= 4'd10;
                a2_live[i] <= 4'd14;
                b_live[i]  <= B_RST;
            end
        end else if (cfg_wr && int'(cfg_ch) < channels) begin
            a1_live[cfg_ch[CW-1:0]] <= clamp_a(cfg_a1);
            a2_live[cfg_ch[CW-1:0]] <= clamp_a(cfg_a2);
            b_live[cfg_ch[CW-1:0]]  <= clamp_b(cfg_b);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < channels; i++) begin
                a1_snap[i] <= 4'd10;
                a2_snap[i] <= 4'd14;
                b_snap[i]  <= B_RST;
                d_cap[i]   <= '0;
            end
        end else if (start) begin
            for (int i = 0; i < channels; i++) begin
                a1_snap[i] <= a1_live[i];
                a2_snap[i] <= a2_live[i];
                b_snap[i]  <= b_live[i];
                d_cap[i]   <= d[i*inputwidth +: inputwidth];
            end
        end
    end

    // Shared datapath for the channel selected by ch: shifts and adds only.
    always_comb begin
        x0   = outputwidth'(d_cap[ch]) <<< (outputwidth - inputwidth);
        diff = (AW'(x0) - AW'(x2[ch])) <<< fracbits;
        xt   = diff >>> b_snap[ch];
        y0   = xt + (y1[ch] <<< 1) - (y1[ch] >>> a1_snap[ch])
                  - y2[ch] + (y2[ch] >>> a2_snap[ch]);
        yq   = y0 >>> fracbits;
        if (yq > Q_MAX)
            q_sat = Q_MAX[outputwidth-1:0];
        else if (yq < Q_MIN)
            q_sat = Q_MIN[outputwidth-1:0];
        else
            q_sat = yq[outputwidth-1:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < channels; i++) begin
                x1[i]    <= '0;
                x2[i]    <= '0;
                y1[i]    <= '0;
                y2[i]    <= '0;
                q_reg[i] <= '0;
            end
        end else if (step) begin
            x2[ch]    <= x1[ch];
            x1[ch]    <= x0;
            y2[ch]    <= y1[ch];
            y1[ch]    <= y0;
            q_reg[ch] <= q_sat;
        end
    end

    always_comb begin
        q = '0;
        for (int i = 0; i < channels; i++)
            q[i*outputwidth +: outputwidth] = q_reg[i];
    end

    assign busy = (state == RUN);

endmodule

// File: tb/tb_iirbandpass_mc.sv
// Self-checking bench for iirbandpass_mc: directed scenarios plus randomized frames
// compared against a frame-level arithmetic model of the filter.
module tb_iirbandpass_mc;

    localparam int IW = 16;
    localparam int OW = 16;
    localparam int CH = 4;
    localparam int FB = 10;
    localparam int AW = OW + FB + 3;

    logic clk = 1'b0;
    logic reset_n;
    logic ena;
    logic [CH*IW-1:0] d;
    logic cfg_wr;
    logic [3:0] cfg_ch, cfg_a1, cfg_a2, cfg_b;
    logic [CH*OW-1:0] q;
    logic q_valid, busy, overrun;

    int total = 0;
    int bad = 0;

    longint mx1 [CH], mx2 [CH], my1 [CH], my2 [CH];
    int la1 [CH], la2 [CH], lb [CH];
    int sa1 [CH], sa2 [CH], sb [CH];
    longint expq [CH], oldq [CH];
    bit expOverrun;

    always #5 clk = ~clk;

    iirbandpass_mc #(
        .inputwidth(IW), .outputwidth(OW), .channels(CH), .fracbits(FB)
    ) dut (
        .clk(clk), .reset_n(reset_n), .ena(ena), .d(d),
        .cfg_wr(cfg_wr), .cfg_ch(cfg_ch), .cfg_a1(cfg_a1), .cfg_a2(cfg_a2), .cfg_b(cfg_b),
        .q(q), .q_valid(q_valid), .busy(busy), .overrun(overrun)
    );

    task automatic checkOutput(input string tag, input longint obs, input longint exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic longint laneOut(input int n);
        return longint'(q[n*OW +: OW]);
    endfunction

    function automatic logic [CH*IW-1:0] oneLane(input int n, input logic [IW-1:0] v);
        logic [CH*IW-1:0] r;
        r = '0;
        r[n*IW +: IW] = v;
        return r;
    endfunction

    function automatic longint wrapAw(input longint v);
        return (v <<< (64 - AW)) >>> (64 - AW);
    endfunction

    function automatic void modelReset();
        for (int n = 0; n < CH; n++) begin
            mx1[n] = 0; mx2[n] = 0; my1[n] = 0; my2[n] = 0;
            la1[n] = 10; la2[n] = 14; lb[n] = 10;
            expq[n] = 0;
        end
        expOverrun = 1'b0;
    endfunction

    function automatic void modelWrite(input int c, input int a1, input int a2, input int b);
        if (c < CH) begin
            la1[c] = (a1 < 1) ? 1 : a1;
            la2[c] = (a2 < 1) ? 1 : a2;
            lb[c]  = (b > FB) ? FB : b;
        end
    endfunction

    // One whole frame: every channel's difference equation, then saturation of y0/2^FB.
    function automatic void modelFrame(input logic [CH*IW-1:0] din);
        longint x0, xt, y0, yq;
        longint qmax = (64'sd1 <<< (OW - 1)) - 1;
        longint qmin = -(64'sd1 <<< (OW - 1));
        for (int n = 0; n < CH; n++) begin
            x0 = longint'($signed(din[n*IW +: IW])) <<< (OW - IW);
            xt = wrapAw((x0 - mx2[n]) <<< FB) >>> sb[n];
            y0 = wrapAw(xt + 2 * my1[n] - (my1[n] >>> sa1[n]) - my2[n] + (my2[n] >>> sa2[n]));
            yq = y0 >>> FB;
            if (yq > qmax) yq = qmax;
            if (yq < qmin) yq = qmin;
            expq[n] = yq & ((64'sd1 <<< OW) - 1);
            mx2[n] = mx1[n]; mx1[n] = x0;
            my2[n] = my1[n]; my1[n] = y0;
        end
    endfunction

    task automatic resetDut();
        reset_n = 1'b0; ena = 1'b0; cfg_wr = 1'b0; d = '0;
        cfg_ch = '0; cfg_a1 = '0; cfg_a2 = '0; cfg_b = '0;
        modelReset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic cfgWrite(input int c, input int a1, input int a2, input int b);
        cfg_wr = 1'b1; cfg_ch = 4'(c); cfg_a1 = 4'(a1); cfg_a2 = 4'(a2); cfg_b = 4'(b);
        modelWrite(c, a1, a2, b);
        @(negedge clk);
        cfg_wr = 1'b0;
    endtask

    // Called at a negedge; runs one frame and checks every lane on every cycle.
    task automatic applyStimulus(input logic [CH*IW-1:0] din, input bit doCfg,
                                 input int cc, input int ca1, input int ca2, input int cb,
                                 input int extraEnaAt, input bit backToBack);
        for (int n = 0; n < CH; n++) oldq[n] = expq[n];
        d = din; ena = 1'b1;
        if (doCfg) begin
            cfg_wr = 1'b1; cfg_ch = 4'(cc); cfg_a1 = 4'(ca1); cfg_a2 = 4'(ca2); cfg_b = 4'(cb);
        end
        for (int n = 0; n < CH; n++) begin
            sa1[n] = la1[n]; sa2[n] = la2[n]; sb[n] = lb[n];
        end
        if (doCfg) modelWrite(cc, ca1, ca2, cb);
        modelFrame(din);
        @(negedge clk);
        ena = 1'b0; cfg_wr = 1'b0;
        checkOutput("busy_start", busy, 1);
        checkOutput("q_valid_start", q_valid, 0);
        for (int n = 0; n < CH; n++) begin
            if (n == extraEnaAt) begin
                ena = 1'b1;
                expOverrun = 1'b1;
            end
            @(negedge clk);
            ena = 1'b0;
            for (int k = 0; k < CH; k++)
                checkOutput($sformatf("lane%0d_cyc%0d", k, n), laneOut(k),
                            (k <= n) ? expq[k] : oldq[k]);
            checkOutput($sformatf("q_valid_cyc%0d", n), q_valid, (n == CH - 1) ? 1 : 0);
            checkOutput($sformatf("busy_cyc%0d", n), busy, (n == CH - 1) ? 0 : 1);
        end
        checkOutput("overrun", overrun, expOverrun);
        if (!backToBack) begin
            @(negedge clk);
            checkOutput("q_valid_after", q_valid, 0);
            checkOutput("busy_after", busy, 0);
        end
    endtask

    task automatic frame(input logic [CH*IW-1:0] din);
        applyStimulus(din, 1'b0, 0, 0, 0, 0, -1, 1'b0);
    endtask

    initial begin
        logic [CH*IW-1:0] din;
        bit doCfg, b2b;

        resetDut();
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_q_valid", q_valid, 0);
        checkOutput("rst_overrun", overrun, 0);
        for (int k = 0; k < CH; k++) checkOutput($sformatf("rst_lane%0d", k), laneOut(k), 0);

        // Impulse response with default coefficients
        frame(oneLane(0, 16'h4000));
        checkOutput("imp_first", laneOut(0), 16);
        frame('0);
        checkOutput("imp_second", laneOut(0), 31);
        for (int k = 1; k < CH; k++) checkOutput($sformatf("imp_idle_lane%0d", k), laneOut(k), 0);

        // Positive and negative saturation with unity gain
        cfgWrite(1, 10, 14, 0);
        frame(oneLane(1, 16'h7FFF));
        checkOutput("pos_sat_first", laneOut(1), 16'h7FFF);
        frame('0);
        checkOutput("pos_sat_second", laneOut(1), 16'h7FFF);
        cfgWrite(2, 10, 14, 0);
        frame(oneLane(2, 16'h8000));
        checkOutput("neg_sat_first", laneOut(2), 16'h8000);
        frame('0);
        checkOutput("neg_sat_second", laneOut(2), 16'h8000);

        // Overrun: a second strobe two cycles into the frame
        applyStimulus(oneLane(3, 16'h1234), 1'b0, 0, 0, 0, 0, 1, 1'b0);
        frame('0);

        // Coefficient write coinciding with the strobe affects the next frame only
        applyStimulus(oneLane(0, 16'h1000), 1'b1, 0, 10, 14, 0, -1, 1'b0);
        frame(oneLane(0, 16'h1000));

        // Clamping and an out-of-range channel index
        cfgWrite(3, 0, 0, 15);
        cfgWrite(CH, 1, 1, 0);
        frame(oneLane(3, 16'h2000));
        frame('0);

        // Reset in the middle of a frame
        d = oneLane(0, 16'h4000); ena = 1'b1;
        @(negedge clk);
        ena = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_q_valid", q_valid, 0);
        checkOutput("midrst_overrun", overrun, 0);
        for (int k = 0; k < CH; k++) checkOutput($sformatf("midrst_lane%0d", k), laneOut(k), 0);
        modelReset();
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        frame(oneLane(0, 16'h4000));
        checkOutput("rerun_first", laneOut(0), 16);
        frame('0);
        checkOutput("rerun_second", laneOut(0), 31);

        // Randomized frames, coefficient writes and back-to-back strobes
        for (int it = 0; it < 40; it++) begin
            for (int n = 0; n < CH; n++) begin
                case ($urandom_range(0, 3))
                    0:       din[n*IW +: IW] = 16'h7FFF;
                    1:       din[n*IW +: IW] = 16'h8000;
                    default: din[n*IW +: IW] = 16'($urandom);
                endcase
            end
            if ($urandom_range(0, 2) == 0)
                cfgWrite(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                         int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
            doCfg = ($urandom_range(0, 2) == 0);
            b2b   = ($urandom_range(0, 1) == 0);
            applyStimulus(din, doCfg, int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
                          int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), -1, b2b);
        end

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
